// File: rtl/cart_bus_sequencer.sv
// Cartridge bus cycle sequencer: one CPU byte request -> SETUP/STROBE/RECOVER bus cycle, read data returned on rsp pulse.
// Latency: rsp_valid at SETUP_CYC+STROBE_CYC+1 after accept, ready again one RECOVER_CYC later (ROM latch hit: 1 cycle).
// Backpressure: req_ready is low for the whole bus cycle; only one cycle outstanding. Optional ROM read latch: CART_BUS_ROM_LATCH_EN.
module cart_bus_sequencer #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_wr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [14:0] cart_addr,
  output logic        cart_a15,
  output logic        nCS,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic [7:0]  cart_di,
  input  logic        cart_oe,
  input  logic [7:0]  cram_do,
  input  logic [7:0]  cart_dq_in
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  // Phase counter reload values (phase length minus one).
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       wr_q;
  logic       accept;
  logic       start;
  logic       strobe_last;
  logic       lat_hit;
  logic [7:0] rd_sample;

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign start       = accept && !lat_hit;
  assign strobe_last = (state == ST_STROBE) && (cnt == 4'd0);
  // Mapper data wins when it drives; writes always report zero.
  assign rd_sample   = wr_q ? 8'h00 : (cart_oe ? cram_do : cart_dq_in);

  // Strobes and chip select decode straight from state so reset drops them at once.
  assign cart_rd = (state == ST_STROBE) && !wr_q;
  assign cart_wr = (state == ST_STROBE) && wr_q;
  assign nCS     = !((state != ST_IDLE) && cart_a15 && (cart_addr[14:13] == 2'b01));

`ifdef CART_BUS_ROM_LATCH_EN
  logic        lat_vld;
  logic [15:0] lat_addr;
  logic [7:0]  lat_data;

  assign lat_hit = accept && !req_wr && !req_addr[15] && lat_vld && (lat_addr == req_addr);

  // Single-entry ROM read latch: filled by completed ROM reads, dropped on any write (banking may change).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lat_vld  <= 1'b0;
      lat_addr <= 16'h0000;
      lat_data <= 8'h00;
    end else if (accept && req_wr) begin
      lat_vld <= 1'b0;
    end else if (strobe_last && !wr_q && !cart_a15) begin
      lat_vld  <= 1'b1;
      lat_addr <= {cart_a15, cart_addr};
      lat_data <= rd_sample;
    end
  end
`else
  assign lat_hit = 1'b0;
`endif

  // Phase sequencer: each phase loads its length-1 and advances when the counter reaches zero.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SETUP;
            cnt   <= SETUP_LD;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            state <= ST_STROBE;
            cnt   <= STROBE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            state <= ST_RECOVER;
            cnt   <= RECOVER_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  // Bus-side request registers, held from accept until the next bus cycle starts.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_addr <= 15'h0000;
      cart_a15  <= 1'b0;
      cart_di   <= 8'h00;
      wr_q      <= 1'b0;
    end else if (start) begin
      cart_addr <= req_addr[14:0];
      cart_a15  <= req_addr[15];
      cart_di   <= req_wdata;
      wr_q      <= req_wr;
    end
  end

  // Response: capture on the last strobe cycle, pulse valid on the first recover cycle (or after a latch hit).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= strobe_last || lat_hit;
      if (strobe_last) begin
        rsp_rdata <= rd_sample;
      end
`ifdef CART_BUS_ROM_LATCH_EN
      else if (lat_hit) begin
        rsp_rdata <= lat_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cart_bus_sequencer.sv
// Randomized bench for cart_bus_sequencer: two instances (default 1/4/1 and 2/3/2 timing).
// Expected per-cycle waveforms are derived from the phase lengths relative to the accept cycle.
// Honours CART_BUS_ROM_LATCH_EN with a matching ROM latch model.
module tb_cart_bus_sequencer;

  localparam int S_A = 1, T_A = 4, R_A = 1;
  localparam int S_B = 2, T_B = 3, R_B = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_wr;
  logic [7:0]  req_wdata;
  logic        cart_oe;
  logic [7:0]  cram_do;
  logic [7:0]  cart_dq_in;
  int          sel;

  logic        rdy_a, vld_a, ncs_a, rd_a, wr_a, a15_a;
  logic [7:0]  rdata_a, di_a;
  logic [14:0] addr_a;
  logic        rdy_b, vld_b, ncs_b, rd_b, wr_b, a15_b;
  logic [7:0]  rdata_b, di_b;
  logic [14:0] addr_b;

  logic        o_ready, o_vld, o_ncs, o_rd, o_wr;
  logic [7:0]  o_rdata, o_di;
  logic [15:0] o_addr;

  int checks = 0;
  int errors = 0;

  // Reference ROM latch state, one per instance.
  logic        lat_v [2];
  logic [15:0] lat_a [2];
  logic [7:0]  lat_d [2];

  always #5 clk_sys = ~clk_sys;

  cart_bus_sequencer u_a (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(req_valid && (sel == 0)), .req_ready(rdy_a),
    .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_valid(vld_a), .rsp_rdata(rdata_a),
    .cart_addr(addr_a), .cart_a15(a15_a), .nCS(ncs_a),
    .cart_rd(rd_a), .cart_wr(wr_a), .cart_di(di_a),
    .cart_oe(cart_oe), .cram_do(cram_do), .cart_dq_in(cart_dq_in)
  );

  cart_bus_sequencer #(.SETUP_CYC(S_B), .STROBE_CYC(T_B), .RECOVER_CYC(R_B)) u_b (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_valid(req_valid && (sel == 1)), .req_ready(rdy_b),
    .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata),
    .rsp_valid(vld_b), .rsp_rdata(rdata_b),
    .cart_addr(addr_b), .cart_a15(a15_b), .nCS(ncs_b),
    .cart_rd(rd_b), .cart_wr(wr_b), .cart_di(di_b),
    .cart_oe(cart_oe), .cram_do(cram_do), .cart_dq_in(cart_dq_in)
  );

  assign o_ready = (sel == 1) ? rdy_b   : rdy_a;
  assign o_vld   = (sel == 1) ? vld_b   : vld_a;
  assign o_ncs   = (sel == 1) ? ncs_b   : ncs_a;
  assign o_rd    = (sel == 1) ? rd_b    : rd_a;
  assign o_wr    = (sel == 1) ? wr_b    : wr_a;
  assign o_rdata = (sel == 1) ? rdata_b : rdata_a;
  assign o_di    = (sel == 1) ? di_b    : di_a;
  assign o_addr  = (sel == 1) ? {a15_b, addr_b} : {a15_a, addr_a};

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t observed=%0h required=%0h", tag, sel, $time, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_rsp_valid"}, o_vld, 0);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_addr"}, o_addr, 0);
    check({tag, "_ncs"}, o_ncs, 1);
    check({tag, "_rd"}, o_rd, 0);
    check({tag, "_wr"}, o_wr, 0);
    check({tag, "_di"}, o_di, 0);
  endtask

  // One request on the selected instance; every cycle until ready returns is compared.
  task automatic run_req(input logic [15:0] addr, input logic wr, input logic [7:0] wd,
                         input logic oe, input logic [7:0] cd, input logic [7:0] dq);
    int s, t, r, n;
    bit cs, hit;
    logic [7:0] exp_d;
    s = (sel == 1) ? S_B : S_A;
    t = (sel == 1) ? T_B : T_A;
    r = (sel == 1) ? R_B : R_A;
    cs = (addr[15:13] == 3'b101);
    exp_d = wr ? 8'h00 : (oe ? cd : dq);
    hit = 1'b0;
`ifdef CART_BUS_ROM_LATCH_EN
    hit = !wr && !addr[15] && lat_v[sel] && (lat_a[sel] == addr);
    if (hit) exp_d = lat_d[sel];
`endif
    @(negedge clk_sys);
    req_valid = 1'b1; req_addr = addr; req_wr = wr; req_wdata = wd;
    cart_oe = oe; cram_do = cd; cart_dq_in = dq;
    check("ready_at_accept", o_ready, 1);
    if (hit) begin
      @(negedge clk_sys);
      req_valid = 1'b0;
      check("hit_rsp_valid", o_vld, 1);
      check("hit_rdata", o_rdata, exp_d);
      check("hit_ready", o_ready, 1);
      check("hit_no_rd", o_rd, 0);
      check("hit_ncs", o_ncs, 1);
      return;
    end
    n = s + t + r + 1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_sys);
      check("ready", o_ready, (c >= s + t + r + 1) ? 1 : 0);
      check("cart_rd", o_rd, (!wr && c >= s + 1 && c <= s + t) ? 1 : 0);
      check("cart_wr", o_wr, (wr && c >= s + 1 && c <= s + t) ? 1 : 0);
      check("ncs", o_ncs, (cs && c <= s + t + r) ? 0 : 1);
      check("rsp_valid", o_vld, (c == s + t + 1) ? 1 : 0);
      if (c == s + t + 1) check("rsp_rdata", o_rdata, exp_d);
      check("cart_addr", o_addr, addr);
      check("cart_di", o_di, wd);
      // Request fields are don't-care while busy; bus data only after it has been sampled.
      req_valid = (c < s + t + r) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr = 16'($urandom); req_wr = 1'($urandom); req_wdata = 8'($urandom);
      if (c > s + t) begin
        cart_oe = 1'($urandom); cram_do = 8'($urandom); cart_dq_in = 8'($urandom);
      end
    end
    if (wr) lat_v[sel] = 1'b0;
    else if (!addr[15]) begin
      lat_v[sel] = 1'b1; lat_a[sel] = addr; lat_d[sel] = exp_d;
    end
  endtask

  initial begin
    logic [15:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_wdata = '0;
    cart_oe = 1'b0; cram_do = '0; cart_dq_in = '0; sel = 0;
    for (int i = 0; i < 2; i++) begin lat_v[i] = 1'b0; lat_a[i] = '0; lat_d[i] = '0; end
    #2;
    sel = 0; check_reset_values("rst_a");
    sel = 1; check_reset_values("rst_b");
    @(negedge clk_sys); @(negedge clk_sys);
    reset_n = 1'b1;

    // Directed cases.
    sel = 0; run_req(16'h4123, 1'b0, 8'h00, 1'b0, 8'h77, 8'h5A);
    sel = 1; run_req(16'hA010, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h00);
    sel = 0; run_req(16'hA000, 1'b0, 8'h00, 1'b1, 8'h99, 8'h11);
    sel = 0; run_req(16'h0100, 1'b0, 8'h00, 1'b0, 8'h00, 8'hC3);
    sel = 0; run_req(16'h0100, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C);
    sel = 0; run_req(16'h2000, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00);
    sel = 0; run_req(16'h0100, 1'b0, 8'h00, 1'b1, 8'hE7, 8'h00);

    // Reset in the middle of a read strobe.
    sel = 0;
    @(negedge clk_sys);
    req_valid = 1'b1; req_addr = 16'h4123; req_wr = 1'b0; req_wdata = 8'h00;
    @(negedge clk_sys); req_valid = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("mid_rd_before_reset", o_rd, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    for (int i = 0; i < 2; i++) lat_v[i] = 1'b0;
    @(negedge clk_sys); reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_sys);
      check("post_reset_no_rsp", o_vld, 0);
      check("post_reset_ready", o_ready, 1);
    end

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      sel = i % 2;
      case ($urandom_range(0, 3))
        0: a = {1'b0, 15'($urandom)};
        1: a = 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
        2: a = 16'($urandom);
        default: a = ($urandom_range(0, 1) == 0) ? 16'h0100 : 16'h0200;
      endcase
      run_req(a, ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_bus_sequencer.md
# cart_bus_sequencer

Cartridge bus cycle sequencer that sits directly upstream of the cartridge mapper stage. It turns single-byte CPU-side requests (valid/ready) into phased cartridge bus cycles on `cart_addr`/`cart_a15`/`nCS`/`cart_rd`/`cart_wr`/`cart_di`. It captures read data from the mapper (`cram_do` when `cart_oe`) or from the physical data bus, and returns it with a one-cycle response pulse.

## Interface
Parameters:
- `SETUP_CYC`, 1, cycles address/`nCS` are stable before a strobe; legal range 1..15.
- `STROBE_CYC`, 4, cycles `cart_rd`/`cart_wr` are held high; legal range 1..15.
- `RECOVER_CYC`, 1, cycles address is held after the strobe drops; legal range 1..15.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle; handshake on `req_valid & req_ready`.
- `req_addr`  in  16  CPU address.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for reads and writes.
- `rsp_rdata`  out  8  read data; 0 for writes.
- `cart_addr`  out  15  to mapper, `req_addr[14:0]`.
- `cart_a15`  out  1  to mapper, `req_addr[15]`.
- `nCS`  out  1  active-low; low during cycles to A000–BFFF.
- `cart_rd`  out  1  read strobe.
- `cart_wr`  out  1  write strobe.
- `cart_di`  out  8  write data to mapper.
- `cart_oe`  in  1  mapper drives read data.
- `cram_do`  in  8  mapper read data.
- `cart_dq_in`  in  8  physical cartridge data bus.

## Operation
- Handshake and sequencing:
  - States: IDLE, SETUP, STROBE, RECOVER.
  - `req_ready` = (state == IDLE).
  - IDLE + handshake latches addr/wr/wdata into the output registers and enters SETUP.
- Address and chip select:
  - `cart_addr`, `cart_a15` and `cart_di` are registered at accept and held until the next accept.
  - `nCS` = 0 from accept through the end of RECOVER when `req_addr[15:13]==3'b101`; otherwise 1.
- Strobes:
  - In STROBE, `cart_rd = ~wr` and `cart_wr = wr`.
  - Both strobes are 0 in all other states.
- Read capture:
  - On the final STROBE cycle, `rsp_rdata <= cart_oe ? cram_do : cart_dq_in`.
  - Writes load 0.
- Completion:
  - `rsp_valid` pulses for one cycle on the first RECOVER cycle.
  - After RECOVER_CYC cycles the state returns to IDLE and `nCS` returns to 1.
- Phase counter: a single 4-bit down-counter, loaded with the phase length minus 1 on each phase entry. The phase advances when the counter is 0.
- No request is ever dropped or reordered; at most one bus cycle is outstanding.

## Timing
- Handshake at cycle 0:
  - SETUP runs cycles 1..S.
  - STROBE runs cycles S+1..S+T.
  - `rsp_valid` occurs at S+T+1.
  - `req_ready` is high again at S+T+R+1.
- Defaults (1, 4, 1): strobe cycles 2–5, `rsp_valid` at 6, ready at 7; throughput is one request per 7 cycles.
- Read data is sampled at the clock edge ending cycle S+T. Data must be valid by then.
- Reset values: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `cart_addr` = 0, `cart_a15` = 0, `nCS` = 1, `cart_rd` = 0, `cart_wr` = 0, `cart_di` = 0, state = IDLE.
- Reset asserted mid-cycle: strobes drop immediately (asynchronous); no `rsp_valid` is issued for the aborted request.
- `req_valid` is ignored outside IDLE. Request fields may change while `req_ready` is 0.

## Configuration
- `CART_BUS_ROM_LATCH_EN` defined: single-entry ROM read latch {valid, addr[15:0], data[7:0]}.
  - Hit: read accepted in IDLE with `req_addr[15]==0`, entry valid and address match. No bus cycle runs; state stays IDLE; `rsp_valid`/`rsp_rdata` are returned the next cycle.
  - Back-to-back hits complete one per cycle.
  - Fill: on a completed ROM read.
  - Invalidate: on any accepted write (mapper register writes change banking) and on reset.
- Not defined: every read runs a full bus cycle; no latch storage is present.

## Test plan
- Read 0x4123, `cart_oe`=0, `cart_dq_in`=0x5A, defaults -> `nCS`=1 throughout, `cart_rd` high cycles 2–5, `rsp_valid` at cycle 6 with 0x5A, `req_ready` back at 7.
- Write 0xA010 data 0x3C, SETUP/STROBE/RECOVER = 2/3/2 -> `nCS`=0 cycles 1–7, `cart_wr` high cycles 3–5, `cart_di`=0x3C, `rsp_valid` at 6 with data 0, ready at 8.
- Read 0xA000 with `cart_oe`=1, `cram_do`=0x99, `cart_dq_in`=0x11 -> `rsp_rdata`=0x99.
- Assert `reset_n`=0 during cycle 3 of a read -> `cart_rd` 0 immediately, no `rsp_valid`, all outputs at reset values, `req_ready`=1 after release.
- With `CART_BUS_ROM_LATCH_EN`: read 0x0100 twice -> second read has no `cart_rd` and `rsp_valid` 1 cycle after accept. Write 0x2000 then read 0x0100 -> full bus cycle.
